// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR-register write controller.
// Counter widths cover SETTLE up to 15 and MAX_RETRY up to 7.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;
  localparam int RETRY_W  = 3;

  // Returns {s, r} for one bit; the two terms are mutually exclusive by construction.
  function automatic logic [1:0] excite_bit(input logic d, input logic q);
    return {d & ~q, ~d & q};
  endfunction

endpackage

// File: rtl/sr_excite.sv
// Per-bit S/R excitation: set bits that must rise, reset bits that must fall.
module sr_excite
  import sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {s[i], r[i]} = excite_bit(target[i], q[i]);
  end

endmodule

// File: rtl/sr_reg_driver.sv
// Write-side controller for an SR-flop register: drive, settle, read back,
// retry on mismatch and report done or err.
module sr_reg_driver
  import sr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rd_data
);

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    target, target_nxt, rd_data_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [RETRY_W-1:0]  retry_cnt, retry_nxt;
  logic                done_nxt, err_nxt;
  logic [WIDTH-1:0]    s_drive, r_drive;

  sr_excite #(.WIDTH(WIDTH)) u_excite (
    .target (target),
    .q      (q_in),
    .s      (s_drive),
    .r      (r_drive)
  );

  // Excitation is gated by state so S/R drop to 0 on the same edge that leaves DRIVE or resets.
  assign s_out    = (state == DRIVE) ? s_drive : '0;
  assign r_out    = (state == DRIVE) ? r_drive : '0;
  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt   = state;
    target_nxt  = target;
    settle_nxt  = settle_cnt;
    retry_nxt   = retry_cnt;
    rd_data_nxt = rd_data;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_valid) begin
          target_nxt = wr_data;
          retry_nxt  = '0;
          state_nxt  = DRIVE;
        end
      end
      DRIVE: begin
        settle_nxt = SETTLE_W'(SETTLE);
        state_nxt  = WAIT;
      end
      WAIT: begin
        settle_nxt = settle_cnt - SETTLE_W'(1);
        if (settle_cnt <= SETTLE_W'(1)) state_nxt = CHECK;
      end
      CHECK: begin
        rd_data_nxt = q_in;
        state_nxt   = IDLE;
        // An X on q_in makes this compare unknown, which falls through as a mismatch.
        if (q_in == target) begin
          done_nxt = 1'b1;
        end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
          retry_nxt = retry_cnt + RETRY_W'(1);
          state_nxt = DRIVE;
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      settle_cnt <= '0;
      retry_cnt  <= '0;
      rd_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      target     <= target_nxt;
      settle_cnt <= settle_nxt;
      retry_cnt  <= retry_nxt;
      rd_data    <= rd_data_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sr_reg_driver.sv
// Directed and randomised checks of sr_reg_driver against a behavioural
// SR-register model with an optional stuck-at-0 bit.
module tb_sr_reg_driver;

  localparam int SETTLE_TB = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic [7:0] q_in;
  logic [7:0] s_out;
  logic [7:0] r_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] rd_data;

  logic [7:0] q_reg;
  logic [7:0] stuck0;
  logic       load_en;
  logic [7:0] load_val;
  logic       mon_en = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_reg_driver #(.WIDTH(8), .SETTLE(SETTLE_TB), .MAX_RETRY(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .q_in     (q_in),
    .s_out    (s_out),
    .r_out    (r_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rd_data  (rd_data)
  );

  // SR register model: S sets, R clears, captured on the rising edge.
  always @(posedge clk) begin
    if (load_en) q_reg <= load_val;
    else         q_reg <= (q_reg | s_out) & ~r_out;
  end
  assign q_in = q_reg & ~stuck0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("s_and_r", {24'd0, s_out & r_out}, 32'd0);
      check("done_and_err", {31'd0, done & err}, 32'd0);
    end
  end

  task automatic load_q(input logic [7:0] val);
    load_en  = 1'b1;
    load_val = val;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Offers one word at a negedge while idle; k counts edges after the accept edge.
  task automatic run_word(input logic [7:0] data,
                          output logic [7:0] s_first, output logic [7:0] r_first,
                          output int drives, output int done_at, output int err_at,
                          output logic wait_clean);
    s_first = '0; r_first = '0; drives = 0; done_at = -1; err_at = -1; wait_clean = 1'b1;
    wr_data  = data;
    wr_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        wr_valid = 1'b0;
        s_first  = s_out;
        r_first  = r_out;
      end
      if ((s_out | r_out) != 8'h00) drives++;
      if (k >= 1 && k <= SETTLE_TB && (s_out | r_out) != 8'h00) wait_clean = 1'b0;
      if (done) begin done_at = k; break; end
      if (err)  begin err_at  = k; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s1, r1, word;
    int         drv, d_at, e_at, b, got_lat, exp_lat;
    logic       clean, leak, got_err, exp_err, seen;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
    load_en = 1'b1; load_val = 8'h00; stuck0 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sr", {16'd0, s_out, r_out}, 32'd0);
    check("rst_pulses", {30'd0, done, err}, 32'd0);
    check("rst_rd", {24'd0, rd_data}, 32'd0);
    rst = 1'b0; load_en = 1'b0;
    @(negedge clk);

    // Plain write from all-zero.
    load_q(8'h00);
    run_word(8'hA5, s1, r1, drv, d_at, e_at, clean);
    check("a5_s", {24'd0, s1}, 32'hA5);
    check("a5_r", {24'd0, r1}, 32'h00);
    check("a5_drives", drv, 1);
    check("a5_done_at", d_at, 4);
    check("a5_rd", {24'd0, rd_data}, 32'hA5);

    // Clearing bits from all-ones.
    load_q(8'hFF);
    run_word(8'h0F, s1, r1, drv, d_at, e_at, clean);
    check("0f_s", {24'd0, s1}, 32'h00);
    check("0f_r", {24'd0, r1}, 32'hF0);
    check("0f_wait_clean", {31'd0, clean}, 32'd1);
    check("0f_done_at", d_at, 4);
    check("0f_rd", {24'd0, rd_data}, 32'h0F);

    // Bit 3 stuck at 0: first try plus three retries, then err.
    load_q(8'h00);
    stuck0 = 8'h08;
    run_word(8'h08, s1, r1, drv, d_at, e_at, clean);
    check("stuck_s", {24'd0, s1}, 32'h08);
    check("stuck_drives", drv, 4);
    check("stuck_done_at", d_at, -1);
    check("stuck_err_at", e_at, 16);
    check("stuck_rd", {24'd0, rd_data}, 32'h00);
    @(negedge clk);
    check("stuck_err_once", {31'd0, err}, 32'd0);
    stuck0 = 8'h00;

    // Target already present: no excitation, normal latency.
    load_q(8'h3C);
    run_word(8'h3C, s1, r1, drv, d_at, e_at, clean);
    check("eq_sr", {16'd0, s1, r1}, 32'd0);
    check("eq_drives", drv, 0);
    check("eq_done_at", d_at, 4);
    check("eq_rd", {24'd0, rd_data}, 32'h3C);

    // Reset during WAIT aborts with no pulse.
    load_q(8'h00);
    wr_data = 8'h55; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    check("abort_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, wr_ready}, 32'd1);
    check("abort_sr", {16'd0, s_out, r_out}, 32'd0);
    check("abort_rd", {24'd0, rd_data}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done || err) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_pulse", {31'd0, seen}, 32'd0);
    run_word(8'h01, s1, r1, drv, d_at, e_at, clean);
    check("post_s", {24'd0, s1}, 32'h00);
    check("post_r", {24'd0, r1}, 32'h54);
    check("post_done_at", d_at, 4);
    check("post_rd", {24'd0, rd_data}, 32'h01);

    // Back-to-back words with wr_valid held; wr_data churns while busy.
    wr_valid = 1'b1;
    for (int w = 0; w < 200; w++) begin
      b       = $urandom_range(0, 8);
      stuck0  = (b < 8) ? 8'(1 << b) : 8'h00;
      word    = 8'($urandom);
      exp_err = (word & stuck0) != 8'h00;
      exp_lat = exp_err ? 16 : 4;
      check("rnd_ready", {31'd0, wr_ready}, 32'd1);
      wr_data = word;
      got_lat = -1; got_err = 1'b0; leak = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        wr_data = 8'($urandom);
        if (done || err) begin
          got_lat = k;
          got_err = err;
          break;
        end
        if (wr_ready) leak = 1'b1;
      end
      check("rnd_latency", got_lat, exp_lat);
      check("rnd_err", {31'd0, got_err}, {31'd0, exp_err});
      check("rnd_rd", {24'd0, rd_data}, {24'd0, word & ~stuck0});
      check("rnd_no_early_accept", {31'd0, leak}, 32'd0);
    end
    wr_valid = 1'b0;
    stuck0   = 8'h00;
    @(negedge clk);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
